// File: rtl/slicer_line_feeder.sv
// Slicer line feeder: buffers a rolling three-row window of a 64-bit word
// image stream and replays the full window to the slicer's three line ports
// once per filtered output row, fetching only one new row per pass.
module slicer_line_feeder #(
    parameter int unsigned WORDS_PER_LINE = 64,
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned NUM_ROWS       = 512,
    parameter int unsigned ROW_W          = 10,
    parameter int unsigned RELEASE_CYC    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_pix_valid,
    input  logic [63:0] i_pix_data,
    output logic        o_pix_ack,
    output logic        o_line1_data_valid,
    output logic [63:0] o_line1_data,
    output logic        o_line2_data_valid,
    output logic [63:0] o_line2_data,
    output logic        o_line3_data_valid,
    output logic [63:0] o_line3_data,
    output logic        o_filter,
    input  logic        i_row_done,
    output logic        o_busy,
    output logic        o_frame_done
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLoad    = 3'd1;
    localparam logic [2:0] StSend    = 3'd2;
    localparam logic [2:0] StFilter  = 3'd3;
    localparam logic [2:0] StRelease = 3'd4;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WORDS_PER_LINE - 1);
    localparam logic [ROW_W-1:0]  LastPass = ROW_W'(NUM_ROWS - 2);
    localparam logic [7:0]        RelLast  = 8'(RELEASE_CYC - 1);

    logic [2:0]        state_q, state_d;
    logic [1:0]        top_q, top_d;
    logic [1:0]        wr_buf_q, wr_buf_d;
    logic [1:0]        load_rows_q, load_rows_d;
    logic [1:0]        rows_in_q, rows_in_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_done_q, rd_done_d;
    logic [ROW_W-1:0]  passes_q, passes_d;
    logic [7:0]        rel_cnt_q, rel_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic              valid_q;
    logic [63:0]       line1_q, line2_q, line3_q;

    logic [63:0] mem0_q [WORDS_PER_LINE];
    logic [63:0] mem1_q [WORDS_PER_LINE];
    logic [63:0] mem2_q [WORDS_PER_LINE];

    logic accept;
    logic issue;

    assign accept = (state_q == StLoad) && i_pix_valid;
    // A read is issued on every SEND cycle until the last address has gone out
    assign issue  = (state_q == StSend) && !rd_done_q;

    function automatic logic [1:0] next_buf(input logic [1:0] b);
        return (b == 2'd2) ? 2'd0 : b + 2'd1;
    endfunction

    // Next-state logic for the frame sequencer and its counters
    always_comb begin
        state_d      = state_q;
        top_d        = top_q;
        wr_buf_d     = wr_buf_q;
        load_rows_d  = load_rows_q;
        rows_in_d    = rows_in_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        rd_done_d    = rd_done_q;
        passes_d     = passes_q;
        rel_cnt_d    = rel_cnt_q;
        frame_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d     = StLoad;
                    load_rows_d = 2'd3;
                    wr_buf_d    = 2'd0;
                    rows_in_d   = 2'd0;
                    passes_d    = '0;
                    wr_addr_d   = '0;
                    // Window must restart at B0 so row 0 lands on line 1
                    top_d       = 2'd0;
                end
            end
            StLoad: begin
                if (i_pix_valid) begin
                    if (wr_addr_q == LastAddr) begin
                        wr_addr_d = '0;
                        wr_buf_d  = next_buf(wr_buf_q);
                        if (rows_in_q + 2'd1 == load_rows_q) begin
                            rows_in_d = 2'd0;
                            rd_addr_d = '0;
                            rd_done_d = 1'b0;
                            state_d   = StSend;
                        end else begin
                            rows_in_d = rows_in_q + 2'd1;
                        end
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
            end
            StSend: begin
                if (!rd_done_q) begin
                    if (rd_addr_q == LastAddr) begin
                        rd_addr_d = '0;
                        rd_done_d = 1'b1;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end else begin
                    // Last word is on the ports this cycle; filter starts after it
                    rd_done_d = 1'b0;
                    state_d   = StFilter;
                end
            end
            StFilter: begin
                if (i_row_done) begin
                    passes_d  = passes_q + ROW_W'(1);
                    rel_cnt_d = 8'd0;
                    state_d   = StRelease;
                end
            end
            StRelease: begin
                if (rel_cnt_q == RelLast) begin
                    if (passes_q == LastPass) begin
                        frame_done_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        // Oldest row's buffer receives the new row and becomes line 3
                        wr_buf_d    = top_q;
                        top_d       = next_buf(top_q);
                        load_rows_d = 2'd1;
                        rows_in_d   = 2'd0;
                        wr_addr_d   = '0;
                        state_d     = StLoad;
                    end
                end else begin
                    rel_cnt_d = rel_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q      <= StIdle;
            top_q        <= 2'd0;
            wr_buf_q     <= 2'd0;
            load_rows_q  <= 2'd0;
            rows_in_q    <= 2'd0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            rd_done_q    <= 1'b0;
            passes_q     <= '0;
            rel_cnt_q    <= 8'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            top_q        <= top_d;
            wr_buf_q     <= wr_buf_d;
            load_rows_q  <= load_rows_d;
            rows_in_q    <= rows_in_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            rd_done_q    <= rd_done_d;
            passes_q     <= passes_d;
            rel_cnt_q    <= rel_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Row RAM writes; only the buffer selected by wr_buf takes the word
    always_ff @(posedge i_clk) begin
        if (accept) begin
            case (wr_buf_q)
                2'd0:    mem0_q[wr_addr_q] <= i_pix_data;
                2'd1:    mem1_q[wr_addr_q] <= i_pix_data;
                default: mem2_q[wr_addr_q] <= i_pix_data;
            endcase
        end
    end

    // Synchronous RAM read straight into the line output registers, rotated by top
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            valid_q <= 1'b0;
            line1_q <= '0;
            line2_q <= '0;
            line3_q <= '0;
        end else begin
            valid_q <= issue;
            if (issue) begin
                case (top_q)
                    2'd0: begin
                        line1_q <= mem0_q[rd_addr_q];
                        line2_q <= mem1_q[rd_addr_q];
                        line3_q <= mem2_q[rd_addr_q];
                    end
                    2'd1: begin
                        line1_q <= mem1_q[rd_addr_q];
                        line2_q <= mem2_q[rd_addr_q];
                        line3_q <= mem0_q[rd_addr_q];
                    end
                    default: begin
                        line1_q <= mem2_q[rd_addr_q];
                        line2_q <= mem0_q[rd_addr_q];
                        line3_q <= mem1_q[rd_addr_q];
                    end
                endcase
            end
        end
    end

    assign o_pix_ack          = (state_q == StLoad);
    assign o_filter           = (state_q == StFilter);
    assign o_busy             = (state_q != StIdle);
    assign o_frame_done       = frame_done_q;
    assign o_line1_data_valid = valid_q;
    assign o_line2_data_valid = valid_q;
    assign o_line3_data_valid = valid_q;
    assign o_line1_data       = line1_q;
    assign o_line2_data       = line2_q;
    assign o_line3_data       = line3_q;

endmodule

// File: tb/tb_slicer_line_feeder.sv
// Bench for slicer_line_feeder: control-path vector table, then whole frames
// checked against an image array (pass p shows rows p, p+1, p+2).
module tb_slicer_line_feeder;

    localparam int W  = 64;
    localparam int NR = 4;
    localparam int RC = 2;

    logic        clk = 1'b0;
    logic        rst, start, pv, rdone;
    logic [63:0] pdata;
    logic        ack, v1, v2, v3, filt, busy, fd;
    logic [63:0] d1, d2, d3;

    always #5 clk = ~clk;

    slicer_line_feeder #(
        .WORDS_PER_LINE(W),
        .ADDR_W        (6),
        .NUM_ROWS      (NR),
        .ROW_W         (10),
        .RELEASE_CYC   (RC)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_start           (start),
        .i_pix_valid       (pv),
        .i_pix_data        (pdata),
        .o_pix_ack         (ack),
        .o_line1_data_valid(v1),
        .o_line1_data      (d1),
        .o_line2_data_valid(v2),
        .o_line2_data      (d2),
        .o_line3_data_valid(v3),
        .o_line3_data      (d3),
        .o_filter          (filt),
        .i_row_done        (rdone),
        .o_busy            (busy),
        .o_frame_done      (fd)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Passive monitor sampled on the falling edge
    bit          mon_en = 1'b0;
    int          ack_cnt = 0, fd_cnt = 0, vdiff_cnt = 0, overlap_cnt = 0, run_len = 0;
    logic [63:0] cap1[$], cap2[$], cap3[$];
    int          runs[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (pv && ack) ack_cnt <= ack_cnt + 1;
            if (fd) fd_cnt <= fd_cnt + 1;
            if ((v1 !== v2) || (v1 !== v3)) vdiff_cnt <= vdiff_cnt + 1;
            if (filt && v1) overlap_cnt <= overlap_cnt + 1;
            if (v1) begin
                run_len <= run_len + 1;
                cap1.push_back(d1);
                cap2.push_back(d2);
                cap3.push_back(d3);
            end else if (run_len != 0) begin
                runs.push_back(run_len);
                run_len <= 0;
            end
        end
    end

    // Reference image: row r, word k
    logic [63:0] img [NR][W];

    task automatic fill_img(input bit rnd);
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < W; k++)
                img[r][k] = rnd ? {$urandom, $urandom} : 64'((r << 8) | k);
    endtask

    task automatic clear_caps;
        cap1.delete();
        cap2.delete();
        cap3.delete();
        runs.delete();
    endtask

    // Host side: push nrows rows starting at first_row, optional random gaps
    task automatic feed(input int first_row, input int nrows, input bit bp, input int rd_at);
        int idx = 0;
        int budget = 0;
        int total = nrows * W;
        bit acc;
        bit rd_sent = 1'b0;
        while (idx < total && budget < 20000) begin
            pv    = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            pdata = img[first_row + idx / W][idx % W];
            rdone = (!rd_sent && rd_at >= 0 && idx == rd_at);
            if (rdone) rd_sent = 1'b1;
            acc = pv && ack;
            tick;
            if (acc) idx++;
            budget++;
        end
        rdone = 1'b0;
        check("feed_complete", 64'(idx), 64'(total));
        // Keep offering junk so any ack outside LOAD would be counted
        pv    = 1'b1;
        pdata = '1;
    endtask

    task automatic check_pass(input int p, input int exp_acks, input int ack_base,
                              input bit start_in_send, input int hold);
        int budget = 0;
        int lows = 0;
        if (start_in_send) begin
            start = 1'b1;
            tick;
            start = 1'b0;
        end
        while (filt !== 1'b1 && budget < 500) begin
            tick;
            budget++;
        end
        check($sformatf("pass%0d_filter_rises", p), 64'(filt), 64'd1);
        pv = 1'b0;
        tick;
        check($sformatf("pass%0d_acks", p), 64'(ack_cnt - ack_base), 64'(exp_acks));
        check($sformatf("pass%0d_runs", p), 64'(runs.size()), 64'd1);
        if (runs.size() > 0) check($sformatf("pass%0d_run_len", p), 64'(runs[0]), 64'(W));
        check($sformatf("pass%0d_words", p), 64'(cap1.size()), 64'(W));
        for (int k = 0; k < W; k++) begin
            if (k < cap1.size()) begin
                check($sformatf("pass%0d_l1_w%0d", p, k), cap1[k], img[p][k]);
                check($sformatf("pass%0d_l2_w%0d", p, k), cap2[k], img[p + 1][k]);
                check($sformatf("pass%0d_l3_w%0d", p, k), cap3[k], img[p + 2][k]);
            end
        end
        check($sformatf("pass%0d_valids_equal", p), 64'(vdiff_cnt), 64'd0);
        check($sformatf("pass%0d_filter_valid_overlap", p), 64'(overlap_cnt), 64'd0);
        repeat (hold) begin
            tick;
            if (filt !== 1'b1) lows++;
        end
        check($sformatf("pass%0d_filter_held", p), 64'(lows), 64'd0);
    endtask

    task automatic release_pass(input int p, input bit last);
        rdone = 1'b1;
        tick;
        rdone = 1'b0;
        check($sformatf("pass%0d_release_c1", p), 64'({filt, ack}), 64'd0);
        tick;
        check($sformatf("pass%0d_release_c2", p), 64'({filt, ack}), 64'd0);
        tick;
        if (last) begin
            check($sformatf("pass%0d_frame_done", p), 64'(fd), 64'd1);
            check($sformatf("pass%0d_busy_low", p), 64'(busy), 64'd0);
        end else begin
            check($sformatf("pass%0d_reload_ack", p), 64'(ack), 64'd1);
        end
    endtask

    task automatic run_frame(input bit rnd, input bit bp, input int hold0);
        int base;
        int fd_base = fd_cnt;
        fill_img(rnd);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("frame_start_busy", 64'(busy), 64'd1);
        clear_caps();
        base = ack_cnt;
        feed(0, 3, bp, -1);
        check_pass(0, 3 * W, base, 1'b1, hold0);
        release_pass(0, NR == 3);
        for (int p = 1; p <= NR - 3; p++) begin
            clear_caps();
            base = ack_cnt;
            feed(p + 2, 1, bp, 10);
            check_pass(p, W, base, 1'b0, 5);
            release_pass(p, p == NR - 3);
        end
        repeat (3) tick;
        check("frame_done_once", 64'(fd_cnt - fd_base), 64'd1);
        check("frame_end_idle", 64'({busy, fd, ack, filt}), 64'd0);
    endtask

    typedef struct {
        logic rst, start, pv, rd;
        logic busy, ack, filt, lv, fd;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int bad;
        int fd_base;
        rst = 1'b0; start = 1'b0; pv = 1'b0; rdone = 1'b0; pdata = '0;

        //            rst   start pv    rd    busy  ack   filt  lv    fd
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            rst   = vecs[i].rst;
            start = vecs[i].start;
            pv    = vecs[i].pv;
            rdone = vecs[i].rd;
            tick;
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
            check($sformatf("vec%0d_ack", i), 64'(ack), 64'(vecs[i].ack));
            check($sformatf("vec%0d_filter", i), 64'(filt), 64'(vecs[i].filt));
            check($sformatf("vec%0d_valid", i), 64'(v1 | v2 | v3), 64'(vecs[i].lv));
            check($sformatf("vec%0d_frame_done", i), 64'(fd), 64'(vecs[i].fd));
        end
        start = 1'b0; pv = 1'b0; rdone = 1'b0; rst = 1'b1;
        mon_en = 1'b1;

        bad = 0;
        repeat (20) begin
            tick;
            if ({busy, ack, filt, fd, v1, v2, v3} !== 7'd0 || {d1, d2, d3} !== 192'd0) bad++;
        end
        check("idle_quiet", 64'(bad), 64'd0);

        // Gap-free frame with row/index words; long filter hold
        run_frame(1'b0, 1'b0, 1000);
        // Random data with host backpressure
        run_frame(1'b1, 1'b1, 5);

        // Abort during FILTER of the first pass
        fill_img(1'b1);
        fd_base = fd_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        clear_caps();
        bad = ack_cnt;
        feed(0, 3, 1'b0, -1);
        check_pass(0, 3 * W, bad, 1'b0, 3);
        rst = 1'b0;
        tick;
        check("midreset_outputs", 64'({filt, v1, v2, v3, busy, ack}), 64'd0);
        rst = 1'b1;
        tick;
        tick;
        check("midreset_no_frame_done", 64'(fd_cnt - fd_base), 64'd0);

        // Fresh frame must reload all three rows with new data
        run_frame(1'b1, 1'b1, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slicer_line_feeder.md
Name: slicer_line_feeder

Overview:
- Transmit side of the three-line slicer interface: accepts a raw image as a 64-bit word stream from the host DMA path and drives the slicer's line1/line2/line3 write ports plus its filter strobe.
- Holds a rolling window of three image rows in internal RAMs. Only one new row is fetched from the host per filtered output row.
- Re-sends the full three-row window each time, because the slicer line buffers are overwritten every pass.

Parameters:
- WORDS_PER_LINE, 64, 64-bit words per image row (8 pixels/word; 512 pixels per row).
- ADDR_W, 6, log2(WORDS_PER_LINE).
- NUM_ROWS, 512, image height in rows; must be ≥3.
- ROW_W, 10, width of row counters; must be ≥ log2(NUM_ROWS)+1.
- RELEASE_CYC, 2, cycles o_filter is held low between passes.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-low reset
- i_start  in  1  single-cycle pulse; starts a frame; sampled only in IDLE
- i_pix_valid  in  1  host word valid
- i_pix_data  in  64  host word; stored and forwarded unmodified (no byte swap)
- o_pix_ack  out  1  host word accepted when i_pix_valid & o_pix_ack
- o_line1_data_valid  out  1  write strobe, slicer line 1 (oldest row)
- o_line1_data  out  64  line 1 word
- o_line2_data_valid  out  1  write strobe, slicer line 2
- o_line2_data  out  64  line 2 word
- o_line3_data_valid  out  1  write strobe, slicer line 3 (newest row)
- o_line3_data  out  64  line 3 word
- o_filter  out  1  filter run request to slicer
- i_row_done  in  1  single-cycle pulse from output collector; slicer output for current pass fully drained
- o_busy  out  1  high in any state except IDLE
- o_frame_done  out  1  one-cycle pulse when the last pass has been released

Behaviour:
- Reset (i_rst=0 at posedge): state=IDLE. All outputs 0; line data outputs 0. Row counters, word counters and window pointer top=0. Reset mid-operation aborts immediately with no completion pulse.
- Storage: three RAMs B0..B2, WORDS_PER_LINE x 64, with synchronous read (1-cycle latency). Window mapping: line1=B[top], line2=B[(top+1)%3], line3=B[(top+2)%3].
- IDLE: on i_start go to LOAD with load_rows=3, wr_buf=0, rows_in=0, passes=0.
- LOAD: o_pix_ack=1.
  - Each accepted word is written to B[wr_buf] at wr_addr, then wr_addr++.
  - After word WORDS_PER_LINE-1: wr_addr wraps to 0, rows_in++, wr_buf=(wr_buf+1)%3.
  - When the required rows are loaded (3 initially, 1 thereafter), go to SEND.
  - o_pix_ack drops the cycle after the last word is accepted. No word is accepted outside LOAD.
- SEND: rd_addr runs 0..WORDS_PER_LINE-1, one per cycle, and is never stalled.
  - All three valids are asserted together for exactly WORDS_PER_LINE consecutive cycles, starting 1 cycle after SEND entry (RAM latency).
  - Word k of each line is presented on the k-th valid cycle.
  - Slicer acks are not used; the slicer write counters free-run modulo 64, so partial lines are forbidden.
  - After the last valid cycle go to FILTER.
- FILTER: o_filter=1 until i_row_done is sampled high, then go to RELEASE with passes++.
  - i_row_done in any other state is ignored.
- RELEASE: o_filter=0 for RELEASE_CYC cycles, which lets the slicer read FSM return to IDLE.
  - If passes==NUM_ROWS-2: pulse o_frame_done and go to IDLE.
  - Otherwise set wr_buf=top, then top=(top+1)%3, load_rows=1, and go to LOAD.
- Simultaneous events: i_start outside IDLE is ignored. i_pix_valid with no ack holds data (host keeps it stable).
- Counters wrap only at the stated bounds; passes never exceeds NUM_ROWS-2.

Test Plan:
- Reset then idle: i_rst=0 for 3 cycles, then 1, no i_start → all outputs 0, o_pix_ack=0, o_busy=0 indefinitely.
- First pass, NUM_ROWS=4:
  - Stimulus: start, feed rows 0,1,2 with word=(row<<8)|idx, no gaps.
  - Required: exactly 192 acks, then 64 cycles with line1=0x000..0x03F, line2=0x100..0x13F, line3=0x200..0x23F, valids contiguous. Then o_filter=1.
- Rolling window:
  - Stimulus: pulse i_row_done, feed row 3.
  - Required: o_filter low ≥2 cycles, only 64 acks, then line1=row1, line2=row2, line3=row3. After the second i_row_done, o_frame_done pulses once and o_busy=0.
- Host backpressure: toggle i_pix_valid randomly at 50% during LOAD → stored data identical to the gap-free run. SEND valids remain 64 contiguous cycles.
- Protocol robustness:
  - i_start pulsed during SEND → ignored.
  - i_row_done pulsed during LOAD → ignored.
  - o_filter stays high through 1000 cycles without i_row_done.
- Reset mid-operation: assert i_rst=0 during FILTER of pass 1 → next cycle o_filter=0 and valids 0. A fresh i_start then reloads 3 rows (192 acks), so no stale window is reused.
